// File: rtl/cipher_pkg.sv
// Shared types and round arithmetic for the stream cipher pipeline.
// Words are carried at MAXW bits and masked to the live width w.
package cipher_pkg;

    localparam int MAXW = 32;
    localparam int MAXA = 16;

    localparam logic MODE_ENC = 1'b0;
    localparam logic MODE_DEC = 1'b1;

    typedef logic [MAXW-1:0] word_t;

    typedef struct packed {
        logic             valid;
        word_t            data;
        word_t            key;
        logic             mode;
        logic             last;
        logic [MAXA-1:0]  tag;
    } stage_t;

    function automatic word_t wmask(input int w);
        if (w >= MAXW)
            return '1;
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t neg_w(input word_t d, input int w);
        return (~d + word_t'(1)) & wmask(w);
    endfunction

    function automatic word_t swap_halves(input word_t d, input int w);
        int    h;
        word_t m;
        h = w / 2;
        m = d & wmask(w);
        return ((m << h) | (m >> h)) & wmask(w);
    endfunction

    function automatic word_t enc_round(
        input word_t           d,
        input word_t           k,
        input logic [MAXA-1:0] t,
        input int              w
    );
        word_t s;
        s = swap_halves(neg_w(d ^ k, w), w);
        return (s + word_t'(t)) & wmask(w);
    endfunction

    // Exact inverse of enc_round for the same key and tag.
    function automatic word_t dec_round(
        input word_t           d,
        input word_t           k,
        input logic [MAXA-1:0] t,
        input int              w
    );
        word_t s;
        s = swap_halves((d - word_t'(t)) & wmask(w), w);
        return (neg_w(s, w) ^ k) & wmask(w);
    endfunction

endpackage

// File: rtl/stream_cipher_pipe_if.sv
// Handshake bundle for stream_cipher_pipe: input beat channel,
// output beat channel and status; master = driver, slave = engine.
interface stream_cipher_pipe_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);

    logic [DATA_WIDTH-1:0] key;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_mode;
    logic                  in_last;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic                  out_last;
    logic                  busy;
    logic                  frame_done;

    modport master (
        output key, in_valid, in_data, in_mode, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_addr, out_last,
        input  busy, frame_done
    );

    modport slave (
        input  key, in_valid, in_data, in_mode, in_last, out_ready,
        output in_ready, out_valid, out_data, out_addr, out_last,
        output busy, frame_done
    );

endinterface

// File: rtl/cipher_round_stage.sv
// One registered cipher round; holds its beat while en is low.
// Ports: clk, rst_n, en, d (incoming beat), q (registered beat).
module cipher_round_stage
    import cipher_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    input  stage_t d,
    output stage_t q
);

    stage_t nxt;

    always_comb begin
        nxt = d;
        if (d.mode == MODE_ENC)
            nxt.data = enc_round(d.data, d.key, d.tag, DATA_WIDTH);
        else
            nxt.data = dec_round(d.data, d.key, d.tag, DATA_WIDTH);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (en)
            q <= nxt;
    end

endmodule

// File: rtl/stream_cipher_pipe.sv
// Pipelined byte-stream cipher: S0 capture, ROUNDS round stages, S_out.
// Ports: clk, rst_n, io (slave side: beats in, tagged beats out, status).
module stream_cipher_pipe
    import cipher_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ROUNDS     = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    stream_cipher_pipe_if.slave io
);

    logic stall;
    logic en;
    logic in_fire;
    logic out_fire;
    logic busy;

    logic [ADDR_WIDTH-1:0] tag_q;

    stage_t s0_q;
    stage_t s0_x;
    stage_t chain [ROUNDS];
    stage_t fin;
    word_t  fin_data;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [ADDR_WIDTH-1:0] out_addr_q;
    logic                  out_last_q;
    logic                  frame_done_q;

    // A held output freezes the whole pipe, bubbles included.
    assign stall    = out_valid_q & ~io.out_ready;
    assign en       = ~stall;
    assign in_fire  = io.in_valid & en;
    assign out_fire = out_valid_q & io.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            tag_q <= '0;
        else if (in_fire)
            tag_q <= io.in_last ? '0 : tag_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0_q <= '0;
        end else if (en) begin
            s0_q.valid <= io.in_valid;
            s0_q.data  <= word_t'(io.in_data);
            s0_q.key   <= word_t'(io.key);
            s0_q.mode  <= io.in_mode;
            s0_q.last  <= io.in_last;
            s0_q.tag   <= MAXA'(tag_q);
        end
    end

    // Decrypt undoes the final XOR before the first round.
    always_comb begin
        s0_x = s0_q;
        if (s0_q.mode == MODE_DEC)
            s0_x.data = s0_q.data ^ s0_q.key;
    end

    for (genvar g = 0; g < ROUNDS; g++) begin : g_rnd
        stage_t d;
        if (g == 0) begin : g_first
            assign d = s0_x;
        end else begin : g_next
            assign d = chain[g-1];
        end
        cipher_round_stage #(
            .DATA_WIDTH (DATA_WIDTH)
        ) u_rnd (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .d     (d),
            .q     (chain[g])
        );
    end

    assign fin      = chain[ROUNDS-1];
    assign fin_data = (fin.mode == MODE_ENC) ? fin.data ^ fin.key
                                             : fin.data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_addr_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (en) begin
            out_valid_q <= fin.valid;
            out_data_q  <= DATA_WIDTH'(fin_data);
            out_addr_q  <= ADDR_WIDTH'(fin.tag);
            out_last_q  <= fin.last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            frame_done_q <= 1'b0;
        else
            frame_done_q <= out_fire & out_last_q;
    end

    always_comb begin
        busy = s0_q.valid | out_valid_q;
        for (int i = 0; i < ROUNDS; i++)
            busy = busy | chain[i].valid;
    end

    assign io.in_ready   = en;
    assign io.out_valid  = out_valid_q;
    assign io.out_data   = out_data_q;
    assign io.out_addr   = out_addr_q;
    assign io.out_last   = out_last_q;
    assign io.busy       = busy;
    assign io.frame_done = frame_done_q;

endmodule

// File: tb/tb_stream_cipher_pipe.sv
// Testbench: ROUNDS=1 and ROUNDS=2 engines on shared input stimulus,
// each checked by a scoreboard built from the cipher's defining rules.
module tb_stream_cipher_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] key = '0;
    logic [7:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_mode = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    stream_cipher_pipe_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) io1 ();
    stream_cipher_pipe_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) io2 ();

    assign io1.key       = key;
    assign io1.in_valid  = in_valid;
    assign io1.in_data   = in_data;
    assign io1.in_mode   = in_mode;
    assign io1.in_last   = in_last;
    assign io1.out_ready = 1'b1;
    assign io2.key       = key;
    assign io2.in_valid  = in_valid;
    assign io2.in_data   = in_data;
    assign io2.in_mode   = in_mode;
    assign io2.in_last   = in_last;
    assign io2.out_ready = out_ready;

    stream_cipher_pipe #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .ROUNDS     (1)
    ) dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io1)
    );

    stream_cipher_pipe #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (4),
        .ROUNDS     (2)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .io    (io2)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Cipher written directly from the round definitions.
    function automatic logic [7:0] model_ct(input logic [7:0] x,
                                            input logic [7:0] k,
                                            input logic m,
                                            input logic [3:0] t,
                                            input int r);
        logic [7:0] d;
        logic [7:0] tt;
        tt = {4'b0, t};
        if (!m) begin
            d = x;
            for (int i = 0; i < r; i++) begin
                d = d ^ k;
                d = 8'd0 - d;
                d = {d[3:0], d[7:4]};
                d = d + tt;
            end
            d = d ^ k;
        end else begin
            d = x ^ k;
            for (int i = 0; i < r; i++) begin
                d = d - tt;
                d = {d[3:0], d[7:4]};
                d = 8'd0 - d;
                d = d ^ k;
            end
        end
        return d;
    endfunction

    // Scoreboard state per engine (index 0: ROUNDS=1, 1: ROUNDS=2).
    logic [7:0] e_dat [2][32];
    logic [3:0] e_tag [2][32];
    logic       e_lst [2][32];
    int         wr [2];
    int         rd [2];
    int         mtag [2];
    int         fdc [2];
    logic       fdx [2];

    logic [7:0] c1_d [$];
    logic [7:0] c2_d [$];
    logic [3:0] c2_a [$];
    logic       c2_l [$];

    logic       m_ov, m_ol, m_ir, m_bz, m_fd, m_rdy;
    logic [7:0] m_od;
    logic [3:0] m_oa;
    int         m_p;

    initial begin
        for (int i = 0; i < 2; i++) begin
            wr[i] = 0; rd[i] = 0; mtag[i] = 0; fdc[i] = 0; fdx[i] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                if (i == 0) begin
                    m_ov = io1.out_valid; m_ol = io1.out_last;
                    m_ir = io1.in_ready;  m_bz = io1.busy;
                    m_fd = io1.frame_done; m_od = io1.out_data;
                    m_oa = io1.out_addr;  m_rdy = 1'b1;
                end else begin
                    m_ov = io2.out_valid; m_ol = io2.out_last;
                    m_ir = io2.in_ready;  m_bz = io2.busy;
                    m_fd = io2.frame_done; m_od = io2.out_data;
                    m_oa = io2.out_addr;  m_rdy = out_ready;
                end
                if (!rst_n) begin
                    wr[i] = 0; rd[i] = 0; mtag[i] = 0; fdx[i] = 1'b0;
                end else begin
                    if (m_fd) fdc[i]++;
                    check($sformatf("frame_done%0d", i + 1), m_fd, fdx[i]);
                    check($sformatf("busy%0d", i + 1), m_bz, wr[i] != rd[i]);
                    check($sformatf("in_ready%0d", i + 1), m_ir,
                          !(m_ov && !m_rdy));
                    fdx[i] = 1'b0;
                    if (m_ov && m_rdy) begin
                        if (wr[i] == rd[i]) begin
                            check($sformatf("spurious%0d", i + 1), 1, 0);
                        end else begin
                            m_p = rd[i] % 32;
                            check($sformatf("data%0d", i + 1), m_od,
                                  e_dat[i][m_p]);
                            check($sformatf("addr%0d", i + 1), m_oa,
                                  e_tag[i][m_p]);
                            check($sformatf("last%0d", i + 1), m_ol,
                                  e_lst[i][m_p]);
                            rd[i]++;
                        end
                        fdx[i] = m_ol;
                        if (i == 0) begin
                            c1_d.push_back(m_od);
                        end else begin
                            c2_d.push_back(m_od);
                            c2_a.push_back(m_oa);
                            c2_l.push_back(m_ol);
                        end
                    end
                    if (in_valid && m_ir) begin
                        m_p = wr[i] % 32;
                        e_dat[i][m_p] = model_ct(in_data, key, in_mode,
                                                 4'(mtag[i]), i + 1);
                        e_tag[i][m_p] = 4'(mtag[i]);
                        e_lst[i][m_p] = in_last;
                        wr[i]++;
                        mtag[i] = in_last ? 0 : (mtag[i] + 1) % 16;
                    end
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and returns just after the edge that takes it.
    task automatic send(input logic [7:0] d, input logic [7:0] kk,
                        input logic m, input logic l);
        int n;
        n = 0;
        in_data  = d;
        key      = kk;
        in_mode  = m;
        in_last  = l;
        in_valid = 1'b1;
        @(negedge clk);
        while (!io2.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((io1.busy || io2.busy) && n < 300);
        if (n >= 300) check("drain_timeout", 1, 0);
        repeat (2) @(negedge clk);
    endtask

    logic [7:0] x [64];
    logic [7:0] k [64];
    logic       m [64];
    logic       lst [64];
    logic [7:0] y [64];
    logic [3:0] ya [64];
    int         l1, l2, nn;
    logic [7:0] kr;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state1", {io1.out_valid, io1.out_data, io1.out_addr,
              io1.out_last, io1.busy, io1.frame_done, io1.in_ready}, 1);
        check("rst_state2", {io2.out_valid, io2.out_data, io2.out_addr,
              io2.out_last, io2.busy, io2.frame_done, io2.in_ready}, 1);
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Single-beat encrypt frame and pipeline latency.
        c1_d.delete();
        fdc[0] = 0;
        sync();
        send(8'h12, 8'h5A, 1'b0, 1'b1);
        l1 = 0;
        l2 = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (io1.out_valid && l1 == 0) begin
                l1 = n;
                check("single_data", io1.out_data, 8'hD1);
                check("single_addr", io1.out_addr, 0);
                check("single_last", io1.out_last, 1);
            end
            if (io2.out_valid && l2 == 0) l2 = n;
        end
        check("latency_r1", l1, 3);
        check("latency_r2", l2, 4);
        drain();
        check("single_frame_done", fdc[0], 1);
        check("single_count", c1_d.size(), 1);

        // Two-beat encrypt frame, then decrypt it back.
        c1_d.delete();
        sync();
        send(8'h12, 8'h5A, 1'b0, 1'b0);
        send(8'h12, 8'h5A, 1'b0, 1'b1);
        drain();
        check("pair_count", c1_d.size(), 2);
        if (c1_d.size() == 2) begin
            check("pair_enc0", c1_d[0], 8'hD1);
            check("pair_enc1", c1_d[1], 8'hD6);
        end
        c1_d.delete();
        sync();
        send(8'hD1, 8'h5A, 1'b1, 1'b0);
        send(8'hD6, 8'h5A, 1'b1, 1'b1);
        drain();
        check("pair_dec_count", c1_d.size(), 2);
        if (c1_d.size() == 2) begin
            check("pair_dec0", c1_d[0], 8'h12);
            check("pair_dec1", c1_d[1], 8'h12);
        end

        // 64-beat mixed-mode loopback with tag wrap.
        for (int i = 0; i < 64; i++) begin
            x[i]   = 8'($urandom);
            k[i]   = 8'($urandom);
            m[i]   = 1'($urandom);
            lst[i] = (i == 40) || (i == 63);
        end
        c2_d.delete(); c2_a.delete(); c2_l.delete();
        sync();
        for (int i = 0; i < 64; i++) send(x[i], k[i], m[i], lst[i]);
        drain();
        check("loop_pass1_count", c2_d.size(), 64);
        for (int i = 0; i < 64; i++) begin
            y[i]  = (i < c2_d.size()) ? c2_d[i] : 8'h00;
            ya[i] = (i < c2_a.size()) ? c2_a[i] : 4'h0;
        end
        check("tag_15", ya[15], 15);
        check("tag_wrap", ya[16], 0);
        check("tag_frame2", ya[41], 0);
        c2_d.delete(); c2_a.delete(); c2_l.delete();
        sync();
        for (int i = 0; i < 64; i++) send(y[i], k[i], !m[i], lst[i]);
        drain();
        check("loop_pass2_count", c2_d.size(), 64);
        for (int i = 0; i < 64 && i < c2_d.size(); i++)
            check($sformatf("loop_%0d", i), c2_d[i], x[i]);

        // Backpressure: out_ready low for 5 cycles mid-stream.
        for (int i = 0; i < 10; i++) begin
            x[i] = 8'($urandom);
            k[i] = 8'($urandom);
        end
        c2_d.delete(); c2_a.delete(); c2_l.delete();
        sync();
        fork
            begin
                for (int i = 0; i < 10; i++)
                    send(x[i], k[i], 1'b0, i == 9);
            end
            begin
                repeat (6) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_valid", io2.out_valid, 1);
                    check("stall_in_ready", io2.in_ready, 0);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        check("stall_count", c2_d.size(), 10);
        for (int i = 0; i < 10 && i < c2_d.size(); i++)
            check($sformatf("stall_%0d", i), c2_d[i],
                  model_ct(x[i], k[i], 1'b0, 4'(i), 2));

        // Asynchronous reset with three beats in flight.
        sync();
        for (int i = 0; i < 3; i++)
            send(8'($urandom), 8'($urandom), 1'b0, 1'b0);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst1", {io1.out_valid, io1.out_data, io1.out_addr,
              io1.out_last, io1.busy, io1.frame_done, io1.in_ready}, 1);
        check("mid_rst2", {io2.out_valid, io2.out_data, io2.out_addr,
              io2.out_last, io2.busy, io2.frame_done, io2.in_ready}, 1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        c2_d.delete(); c2_a.delete(); c2_l.delete();
        kr = 8'hC5;
        sync();
        send(8'h33, kr, 1'b0, 1'b1);
        drain();
        check("post_rst_count", c2_d.size(), 1);
        if (c2_d.size() == 1) begin
            check("post_rst_addr", c2_a[0], 0);
            check("post_rst_data", c2_d[0],
                  model_ct(8'h33, kr, 1'b0, 4'h0, 2));
        end

        // Back-to-back frames of 3 and 2 beats.
        c2_d.delete(); c2_a.delete(); c2_l.delete();
        fdc[1] = 0;
        sync();
        for (int i = 0; i < 5; i++)
            send(8'($urandom), 8'($urandom), 1'($urandom),
                 (i == 2) || (i == 4));
        drain();
        nn = c2_a.size();
        check("frames_count", nn, 5);
        for (int i = 0; i < 5 && i < nn; i++) begin
            check($sformatf("frames_addr%0d", i), c2_a[i],
                  (i < 3) ? i : i - 3);
            check($sformatf("frames_last%0d", i), c2_l[i],
                  (i == 2) || (i == 4));
        end
        check("frames_done", fdc[1], 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/stream_cipher_pipe.md
Name: stream_cipher_pipe

Overview:
- Parametrised, fully pipelined byte-stream cipher engine; one pipeline stage per round.
- A per-beat mode bit selects encrypt or decrypt; both modes share one datapath and pipeline timing.
- Uses a valid/ready handshake with backpressure and explicit frame framing (last), not data-content detection.
- Sits between the input RAM reader and the output RAM writer; emits a write address (tag) with every beat.

Parameters:
- DATA_WIDTH, 8, beat width W; must be even; H = W/2.
- ADDR_WIDTH, 4, width of the beat tag / output write address.
- ROUNDS, 2, number of round stages; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- key  in  DATA_WIDTH  round key; sampled per accepted beat and carried with that beat.
- in_valid  in  1  input beat valid.
- in_ready  out  1  engine can accept a beat.
- in_data  in  DATA_WIDTH  plaintext (encrypt) or ciphertext (decrypt).
- in_mode  in  1  0 = encrypt, 1 = decrypt; sampled per beat.
- in_last  in  1  marks the final beat of a frame.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts the beat.
- out_data  out  DATA_WIDTH  result.
- out_addr  out  ADDR_WIDTH  tag of the beat, used as write address.
- out_last  out  1  final beat of a frame.
- busy  out  1  any stage holds a valid beat.
- frame_done  out  1  one-cycle pulse when a last beat is accepted at the output.

Behaviour:
- Reset (async assert, sync release): all stage valids = 0; tag counter = 0; outputs out_valid, out_data, out_addr, out_last, busy, frame_done = 0; in_ready = 1.
- Handshake: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- stall = out_valid & ~out_ready; in_ready = ~stall (combinational).
- On stall, every stage holds its contents; bubbles are not collapsed.
- Throughput 1 beat/cycle. Latency with no stall: out_valid rises ROUNDS+2 cycles after the accepting edge.
- Stages:
  - S0 captures {data, key, mode, last, tag}.
  - S1..S_ROUNDS each apply one round.
  - S_out applies the final XOR and drives the outputs.
- Operations, all mod 2^W; tag zero-extended to W:
  - neg(d) = ~d + 1.
  - swap(d) = {d[H-1:0], d[W-1:H]}.
- Encrypt round: d <- swap(neg(d ^ key)) + tag. Encrypt final: d ^ key.
- Decrypt: a pre-XOR d ^ key is applied in S0's output path. Each decrypt round is d <- neg(swap(d - tag)) ^ key. Decrypt has no final XOR.
- Requirement: decrypt(encrypt(x)) == x for every x, key, tag and ROUNDS.
- Tag counter:
  - Increments on each input transfer.
  - Returns to 0 on the transfer of a beat with in_last = 1, so the next frame starts at tag 0.
  - Wraps 2^ADDR_WIDTH-1 -> 0 silently mid-frame.
- Mode and key may change on any beat; each beat uses only its own captured values.
- frame_done: high for exactly the cycle after an output transfer with out_last = 1.
- Simultaneous input and output transfer in the same cycle is legal and loses nothing.
- rst_n asserted mid-frame: in-flight beats are discarded and the tag counter is cleared; no partial output is emitted after release.

Decomposition:
- Shared package cipher_pkg:
  - mode constants MODE_ENC/MODE_DEC;
  - functions neg_w, swap_halves, enc_round, dec_round, parameterised by width;
  - a stage record typedef {valid, data, key, mode, last, tag}.
- One sub-module, cipher_round_stage:
  - one registered round, with enable = ~stall;
  - instantiated ROUNDS times via generate.

Test Plan:
- W=8, ROUNDS=1, key=0x5A, encrypt single-beat frame 0x12 (tag 0) -> out_data=0xD1, out_addr=0, out_last=1; out_valid rises exactly 3 cycles after accept; frame_done pulses once.
- Same config, frame {0x12, 0x12} -> outputs 0xD1 (tag 0) then 0xD6 (tag 1); a decrypt frame {0xD1, 0xD6} -> {0x12, 0x12}.
- ROUNDS=2, random 64-beat stream with mixed per-beat mode/key, encrypt then decrypt loopback -> bit-exact recovery; ADDR_WIDTH=4 tags wrap 15->0.
- Hold out_ready=0 for 5 cycles mid-stream -> in_ready=0 in the same cycles, no beat lost or duplicated, order preserved.
- Assert rst_n low while 3 beats are in flight -> all outputs 0 immediately (asynchronous); after release the first new beat gets tag 0 and no stale data appears.
- Back-to-back frames with in_last on beats 3 and 5 -> tags 0,1,2 then 0,1; out_last set on the 3rd and 5th outputs; two frame_done pulses.
